ru_weight_buffer: RTL and testbench

Double-banked (ping-pong) weight store feeding the recompute units (RUs) of the BISR systolic array. A loader streams a full ROWS×COLS weight tile into the shadow bank through a valid/ready handshake. An explicit swap then makes that tile active. NUM_RU independent registered read ports serve RUs from the active bank, so a new tile can be loaded while RUs keep recomputing with the current one.

---
 rtl/ru_weight_buffer.sv | 152 +++++++++++++++
 tb/tb_ru_weight_buffer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ru_weight_buffer.sv
// Ping-pong weight store for the BISR recompute units. A loader fills the shadow bank,
// a swap makes it active, and NUM_RU independent registered read ports serve the active bank.

module ru_wb_rd_port #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int WORD_SIZE = 16,
  parameter int RW        = 2,
  parameter int CW        = 2,
  parameter int AW        = 5
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  en,
  input  logic [RW-1:0]                         row,
  input  logic [CW-1:0]                         col,
  input  logic                                  loaded,
  input  logic [ROWS*COLS-1:0][WORD_SIZE-1:0]   words,
  output logic [WORD_SIZE-1:0]                  weight,
  output logic                                  valid,
  output logic                                  err
);
  logic [AW-1:0]        idx;
  logic                 in_range;
  logic [WORD_SIZE-1:0] data;

  assign idx      = AW'(row) * AW'(COLS) + AW'(col);
  assign in_range = ({1'b0, row} < (RW+1)'(ROWS)) && ({1'b0, col} < (CW+1)'(COLS)) && loaded;

  // Compare-and-select so an out-of-range idx never indexes past the tile.
  always_comb begin
    data = '0;
    for (int k = 0; k < ROWS*COLS; k++)
      if (idx == AW'(k)) data = words[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight <= '0;
      valid  <= 1'b0;
      err    <= 1'b0;
    end else begin
      valid <= en;
      err   <= en && !in_range;
      if (en) weight <= in_range ? data : '0;
    end
  end
endmodule

module ru_weight_buffer #(
  parameter  int ROWS      = 4,
  parameter  int COLS      = 4,
  parameter  int NUM_RU    = 4,
  parameter  int WORD_SIZE = 16,
  localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW        = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int DEPTH     = ROWS * COLS,
  localparam int AW        = $clog2(DEPTH) + 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               ld_start,
  input  logic                               ld_valid,
  output logic                               ld_ready,
  input  logic [WORD_SIZE-1:0]               ld_weight,
  output logic                               ld_done,
  input  logic                               swap,
  output logic                               active_bank,
  input  logic [NUM_RU-1:0]                  rd_en,
  input  logic [NUM_RU-1:0][RW-1:0]          rd_row,
  input  logic [NUM_RU-1:0][CW-1:0]          rd_col,
  output logic [NUM_RU-1:0][WORD_SIZE-1:0]   rd_weight,
  output logic [NUM_RU-1:0]                  rd_valid,
  output logic [NUM_RU-1:0]                  rd_err
);
  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  state_t                              state, state_n;
  logic [AW-1:0]                       ptr;
  logic                                active_loaded;
  logic                                accept, last, do_swap, shadow;
  logic [1:0][DEPTH-1:0][WORD_SIZE-1:0] bank;
  logic [DEPTH-1:0][WORD_SIZE-1:0]     act_words;

  // A word handshaken alongside ld_start belongs to the abandoned tile.
  assign accept    = ld_ready && ld_valid && !ld_start;
  assign last      = accept && (ptr == AW'(DEPTH-1));
  assign do_swap   = (state == FULL) && swap;
  assign shadow    = ~active_bank;
  assign act_words = bank[active_bank];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (ld_start) state_n = LOAD;
      LOAD:    if (ld_start) state_n = LOAD;
               else if (last) state_n = FULL;
      FULL:    if (ld_start) state_n = LOAD;
               else if (swap) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ld_ready = (state == LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr           <= '0;
      active_bank   <= 1'b0;
      active_loaded <= 1'b0;
      ld_done       <= 1'b0;
    end else begin
      ld_done <= last;
      if (ld_start)    ptr <= '0;
      else if (accept) ptr <= last ? '0 : ptr + AW'(1);
      if (do_swap) begin
        active_bank   <= ~active_bank;
        active_loaded <= 1'b1;
      end
    end
  end

  // Tile storage is not reset; active_loaded gates reads until a full tile is swapped in.
  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++)
      if (accept && ptr == AW'(k)) bank[shadow][k] <= ld_weight;
  end

  for (genvar i = 0; i < NUM_RU; i++) begin : g_port
    ru_wb_rd_port #(
      .ROWS(ROWS), .COLS(COLS), .WORD_SIZE(WORD_SIZE), .RW(RW), .CW(CW), .AW(AW)
    ) u_port (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (rd_en[i]),
      .row    (rd_row[i]),
      .col    (rd_col[i]),
      .loaded (active_loaded),
      .words  (act_words),
      .weight (rd_weight[i]),
      .valid  (rd_valid[i]),
      .err    (rd_err[i])
    );
  end
endmodule

// File: tb/tb_ru_weight_buffer.sv
// Bench for ru_weight_buffer: a 4x4/4-port instance and a 3x5/1-port instance, reads
// checked through a per-port scoreboard, loader/swap behaviour checked inline per task.

module tb_ru_weight_buffer;
  logic clk, rst_n;

  logic             ld_start, ld_valid, ld_ready, ld_done, swap, active_bank;
  logic [15:0]      ld_weight;
  logic [3:0]       rd_en, rd_valid, rd_err;
  logic [3:0][1:0]  rd_row, rd_col;
  logic [3:0][15:0] rd_weight;

  logic             o_ld_start, o_ld_valid, o_ld_ready, o_ld_done, o_swap, o_active_bank;
  logic [15:0]      o_ld_weight;
  logic [0:0]       o_rd_en, o_rd_valid, o_rd_err;
  logic [0:0][1:0]  o_rd_row;
  logic [0:0][2:0]  o_rd_col;
  logic [0:0][15:0] o_rd_weight;

  ru_weight_buffer u_dut (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_weight(ld_weight), .ld_done(ld_done), .swap(swap), .active_bank(active_bank),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_weight(rd_weight),
    .rd_valid(rd_valid), .rd_err(rd_err)
  );

  ru_weight_buffer #(.ROWS(3), .COLS(5), .NUM_RU(1), .WORD_SIZE(16)) u_odd (
    .clk(clk), .rst_n(rst_n), .ld_start(o_ld_start), .ld_valid(o_ld_valid), .ld_ready(o_ld_ready),
    .ld_weight(o_ld_weight), .ld_done(o_ld_done), .swap(o_swap), .active_bank(o_active_bank),
    .rd_en(o_rd_en), .rd_row(o_rd_row), .rd_col(o_rd_col), .rd_weight(o_rd_weight),
    .rd_valid(o_rd_valid), .rd_err(o_rd_err)
  );

  typedef struct {int due; bit err; logic [15:0] w;} exp_t;
  exp_t sbq [5][$];

  int checks = 0, errors = 0, cyc = 0;
  logic [15:0] m_base = 16'h0, o_base = 16'h0;
  bit m_loaded = 0, o_loaded = 0, m_bank = 0, o_bank = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: ports 0..3 are the 4x4 instance, port 4 is the 3x5 instance.
  logic mon_v, mon_e;
  logic [15:0] mon_w;
  exp_t mon_x;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < 5; p++) begin
        mon_v = (p < 4) ? rd_valid[p]  : o_rd_valid[0];
        mon_e = (p < 4) ? rd_err[p]    : o_rd_err[0];
        mon_w = (p < 4) ? rd_weight[p] : o_rd_weight[0];
        if (sbq[p].size() > 0 && sbq[p][0].due <= cyc) begin
          mon_x = sbq[p].pop_front();
          checks++;
          if (mon_x.due != cyc || mon_v !== 1'b1 || mon_e !== mon_x.err || mon_w !== mon_x.w) begin
            errors++;
            $display("FAIL rd_port%0d cyc %0d: got v=%b e=%b w=%h, want v=1 e=%b w=%h (due %0d)",
                     p, cyc, mon_v, mon_e, mon_w, mon_x.err, mon_x.w, mon_x.due);
          end
        end else begin
          checks++;
          if (mon_v !== 1'b0 || mon_e !== 1'b0) begin
            errors++;
            $display("FAIL rd_idle%0d cyc %0d: got v=%b e=%b, want v=0 e=0", p, cyc, mon_v, mon_e);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    rd_en   = '0;
    o_rd_en = '0;
  endtask

  task automatic rd_issue(input int p, input int r, input int c);
    exp_t e;
    bit ok;
    if (p < 4) begin
      rd_en[p] = 1'b1; rd_row[p] = r[1:0]; rd_col[p] = c[1:0];
      ok  = (r < 4) && (c < 4) && m_loaded;
      e.w = ok ? 16'(m_base + r*4 + c) : 16'h0;
    end else begin
      o_rd_en[0] = 1'b1; o_rd_row[0] = r[1:0]; o_rd_col[0] = c[2:0];
      ok  = (r < 3) && (c < 5) && o_loaded;
      e.w = ok ? 16'(o_base + r*5 + c) : 16'h0;
    end
    e.err = !ok;
    e.due = cyc + 1;
    sbq[p].push_back(e);
  endtask

  task automatic load_tile(input int dut, input logic [15:0] base, input bit reads);
    int depth = (dut == 0) ? 16 : 15;
    int n = 0, rdy = 0, dn = 0;
    bit r_now, d_now;
    if (dut == 0) ld_start = 1'b1; else o_ld_start = 1'b1;
    step();
    ld_start = 1'b0; o_ld_start = 1'b0;
    for (int i = 0; i < depth + 4; i++) begin
      r_now = (dut == 0) ? ld_ready : o_ld_ready;
      d_now = (dut == 0) ? ld_done  : o_ld_done;
      if (d_now) dn++;
      if (r_now) rdy++;
      if (dut == 0) begin ld_valid = r_now; ld_weight = 16'(base + n); end
      else begin o_ld_valid = r_now; o_ld_weight = 16'(base + n); end
      if (r_now) n++;
      if (reads) for (int p = 0; p < 4; p++) rd_issue(p, p, p);
      step();
    end
    ld_valid = 1'b0; o_ld_valid = 1'b0;
    checks++;
    if (rdy != depth) begin errors++; $display("FAIL load_ready_cycles dut%0d: got %0d, want %0d", dut, rdy, depth); end
    checks++;
    if (dn != 1) begin errors++; $display("FAIL load_done_pulses dut%0d: got %0d, want 1", dut, dn); end
  endtask

  task automatic test_reset();
    #23;
    checks++;
    if (ld_ready !== 1'b0 || ld_done !== 1'b0 || active_bank !== 1'b0 || rd_valid !== 4'h0 ||
        rd_err !== 4'h0 || rd_weight !== 64'h0) begin
      errors++;
      $display("FAIL reset_main: got rdy=%b done=%b bank=%b v=%h e=%h w=%h, want all 0",
               ld_ready, ld_done, active_bank, rd_valid, rd_err, rd_weight);
    end
    checks++;
    if (o_ld_ready !== 1'b0 || o_ld_done !== 1'b0 || o_active_bank !== 1'b0 ||
        o_rd_valid !== 1'b0 || o_rd_err !== 1'b0 || o_rd_weight !== 16'h0) begin
      errors++;
      $display("FAIL reset_odd: got rdy=%b done=%b bank=%b v=%b e=%b w=%h, want all 0",
               o_ld_ready, o_ld_done, o_active_bank, o_rd_valid, o_rd_err, o_rd_weight);
    end
    step();
    rst_n = 1'b1;
    rd_issue(0, 0, 0);
    rd_issue(4, 0, 0);
    step();
    step();
  endtask

  task automatic test_load_basic();
    load_tile(0, 16'h0100, 1'b0);
    checks++;
    if (active_bank !== 1'b0) begin errors++; $display("FAIL bank_before_swap: got %b, want 0", active_bank); end
    swap = 1'b1; step(); swap = 1'b0;
    m_bank = ~m_bank; m_base = 16'h0100; m_loaded = 1'b1;
    checks++;
    if (active_bank !== m_bank) begin errors++; $display("FAIL bank_after_swap: got %b, want %b", active_bank, m_bank); end
    rd_issue(0, 2, 3);
    step();
    step();
    checks++;
    if (rd_weight[0] !== 16'h010B || rd_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL rd_hold: got w=%h v=%b, want w=010b v=0", rd_weight[0], rd_valid[0]);
    end
  endtask

  task automatic test_back_to_back();
    load_tile(0, 16'h0200, 1'b1);
    // reads sampled in the swap cycle still see the old tile
    swap = 1'b1;
    for (int p = 0; p < 4; p++) rd_issue(p, p, p);
    step();
    swap = 1'b0;
    m_bank = ~m_bank; m_base = 16'h0200;
    checks++;
    if (active_bank !== m_bank) begin errors++; $display("FAIL bank_swap2: got %b, want %b", active_bank, m_bank); end
    for (int p = 0; p < 4; p++) rd_issue(p, p, p);
    step();
    swap = 1'b1; step(); swap = 1'b0;
    checks++;
    if (active_bank !== m_bank) begin errors++; $display("FAIL swap_in_idle: got %b, want %b", active_bank, m_bank); end
    step();
  endtask

  task automatic test_swap_in_load();
    ld_start = 1'b1; step(); ld_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_weight = 16'(16'h0D00 + i); swap = 1'b1;
      rd_issue(1, 1, 2);
      step();
      swap = 1'b0;
      checks++;
      if (active_bank !== m_bank) begin errors++; $display("FAIL swap_in_load: got %b, want %b", active_bank, m_bank); end
    end
    ld_valid = 1'b0;
  endtask

  task automatic test_restart();
    int rdy = 0, dn = 0, m = 0, done_at = -1;
    ld_start = 1'b1; step(); ld_start = 1'b0;
    for (int i = 0; i < 7; i++) begin ld_valid = 1'b1; ld_weight = 16'(16'h0E00 + i); step(); end
    ld_start = 1'b1; ld_weight = 16'hDEAD; step(); ld_start = 1'b0;
    checks++;
    if (ld_ready !== 1'b1 || ld_done !== 1'b0) begin
      errors++; $display("FAIL restart_state: got rdy=%b done=%b, want rdy=1 done=0", ld_ready, ld_done);
    end
    for (int i = 0; i < 22; i++) begin
      if (ld_done) begin dn++; done_at = i; end
      if (ld_ready) rdy++;
      ld_valid = ld_ready; ld_weight = 16'(16'h0300 + m);
      if (ld_ready) m++;
      step();
    end
    ld_valid = 1'b0;
    checks++;
    if (rdy != 16 || dn != 1 || done_at != 16) begin
      errors++; $display("FAIL restart_count: got rdy=%0d done=%0d at %0d, want 16 1 at 16", rdy, dn, done_at);
    end
    swap = 1'b1; step(); swap = 1'b0;
    m_bank = ~m_bank; m_base = 16'h0300;
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < 4; p++) rd_issue(p, r, p);
      step();
    end
    step();
  endtask

  task automatic test_odd_shape();
    load_tile(1, 16'h0500, 1'b0);
    o_swap = 1'b1; step(); o_swap = 1'b0;
    o_bank = ~o_bank; o_base = 16'h0500; o_loaded = 1'b1;
    checks++;
    if (o_active_bank !== o_bank) begin errors++; $display("FAIL odd_bank: got %b, want %b", o_active_bank, o_bank); end
    rd_issue(4, 2, 4); step();
    rd_issue(4, 3, 0); step();
    rd_issue(4, 0, 5); step();
    rd_issue(4, 0, 0); step();
    rd_issue(4, 1, 3); step();
    rd_issue(4, 2, 7); step();
    step();
  endtask

  task automatic test_midload_reset();
    ld_start = 1'b1; step(); ld_start = 1'b0;
    for (int i = 0; i < 5; i++) begin ld_valid = 1'b1; ld_weight = 16'(16'h0F00 + i); step(); end
    ld_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ld_ready !== 1'b0 || ld_done !== 1'b0 || active_bank !== 1'b0 || o_active_bank !== 1'b0 ||
        rd_valid !== 4'h0) begin
      errors++;
      $display("FAIL midload_reset: got rdy=%b done=%b bank=%b obank=%b v=%h, want all 0",
               ld_ready, ld_done, active_bank, o_active_bank, rd_valid);
    end
    m_loaded = 1'b0; o_loaded = 1'b0; m_bank = 1'b0; o_bank = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (ld_ready !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got rdy=%b, want 0", ld_ready); end
    rd_issue(0, 0, 0);
    rd_issue(3, 3, 3);
    rd_issue(4, 0, 0);
    step();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_weight = '0; swap = 1'b0;
    rd_en = '0; rd_row = '0; rd_col = '0;
    o_ld_start = 1'b0; o_ld_valid = 1'b0; o_ld_weight = '0; o_swap = 1'b0;
    o_rd_en = '0; o_rd_row = '0; o_rd_col = '0;
    test_reset();
    test_load_basic();
    test_back_to_back();
    test_swap_in_load();
    test_restart();
    test_odd_shape();
    test_midload_reset();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
